// File: rtl/ldpc_shuffle_ctrl_if.sv
// Rotate-command channel into the LDPC shuffle controller.
interface ldpc_shuffle_ctrl_if #(
  parameter int LOG2INSTANCES = 7,
  parameter int CNTWIDTH      = 4
);
  logic                     req_valid;
  logic                     req_ready;
  logic [LOG2INSTANCES-1:0] req_dist;
  logic [CNTWIDTH-1:0]      req_cnt;
  logic                     req_vn;

  modport master (output req_valid, output req_dist, output req_cnt, output req_vn,
                  input  req_ready);
  modport slave  (input  req_valid, input  req_dist, input  req_cnt, input  req_vn,
                  output req_ready);
endinterface

// File: rtl/ldpc_shuffle_ctrl.sv
// Control-side driver for the 3-stage pipelined LDPC barrel rotator.
// Splits a rotate distance into quarter/eighth/unit selects and times each
// select to the rotator stage that consumes it.
//
//  state | meaning
//  IDLE  | no command in progress, req_ready high
//  RUN   | issuing one beat per cycle, beat counter counts down to 0
module ldpc_shuffle_ctrl #(
  parameter int FOLDFACTOR     = 4,
  parameter int NUMINSTANCES   = 360 / FOLDFACTOR,
  // wide enough for 0..NUMINSTANCES-1
  parameter int LOG2INSTANCES  = $clog2(NUMINSTANCES),
  parameter int LASTSHIFTWIDTH = 3,
  parameter int CNTWIDTH       = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  ldpc_shuffle_ctrl_if.slave        req_if,
  output logic                      o_issue,
  output logic                      o_first_half,
  output logic [1:0]                o_shift0,
  output logic [2:0]                o_shift1,
  output logic [LASTSHIFTWIDTH-1:0] o_shift2,
  output logic                      o_sh_valid,
  output logic                      o_sh_last,
  output logic                      o_dist_err
);
  localparam int L  = LOG2INSTANCES;
  localparam int M0 = (FOLDFACTOR == 1) ? 90 : (FOLDFACTOR == 2) ? 45 : (FOLDFACTOR == 3) ? 30 : 23;
  localparam int M1 = (FOLDFACTOR == 1) ? 12 : (FOLDFACTOR == 2) ? 6  : (FOLDFACTOR == 3) ? 4  : 3;
  localparam logic [L-1:0] NUM_W = L'(NUMINSTANCES);
  localparam logic [L-1:0] M0_W  = L'(M0);
  localparam logic [L-1:0] M1_W  = L'(M1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t                    r_state;
  logic                      r_ready;
  logic                      r_issue;
  logic                      r_err;
  logic [CNTWIDTH-1:0]       r_cnt;
  logic                      r_vn;
  logic [1:0]                r_cs0;
  logic [2:0]                r_cs1;
  logic [LASTSHIFTWIDTH-1:0] r_cs2;

  logic                      w_accept;
  logic                      w_legal;
  logic [1:0]                w_s0;
  logic [2:0]                w_s1;
  logic [LASTSHIFTWIDTH-1:0] w_s2;
  logic [L-1:0]              w_r;

  assign w_accept         = req_if.req_valid & r_ready;
  assign req_if.req_ready = r_ready;

  // Distance decomposition: saturating quotients found by threshold compare,
  // which keeps the logic to comparators instead of dividers.
  always_comb begin
    w_legal = (req_if.req_dist < NUM_W);
    w_s0    = 2'd0;
    for (int k = 1; k <= 3; k++) begin
      if (req_if.req_dist >= L'(k * M0)) w_s0 = 2'(k);
    end
    w_r  = req_if.req_dist - (L'(w_s0) * M0_W);
    w_s1 = 3'd0;
    for (int k = 1; k <= 7; k++) begin
      if (w_r >= L'(k * M1)) w_s1 = 3'(k);
    end
    w_s2 = LASTSHIFTWIDTH'(w_r - (L'(w_s1) * M1_W));
    if (!w_legal) begin
      w_s0 = 2'd0;
      w_s1 = 3'd0;
      w_s2 = '0;
    end
  end

  // Command FSM: accept, count beats, back-to-back continuation on last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
      r_issue <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_vn    <= 1'b0;
      r_cs0   <= '0;
      r_cs1   <= '0;
      r_cs2   <= '0;
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        S_IDLE: r_ready <= 1'b1;
        S_RUN: begin
          if (r_cnt != '0) begin
            r_cnt   <= r_cnt - 1'b1;
            r_ready <= (r_cnt == CNTWIDTH'(1));
          end else begin
            r_state <= S_IDLE;
            r_issue <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_accept) begin
        r_state <= S_RUN;
        r_issue <= 1'b1;
        r_cnt   <= req_if.req_cnt;
        r_ready <= (req_if.req_cnt == '0);
        r_vn    <= req_if.req_vn;
        r_cs0   <= w_s0;
        r_cs1   <= w_s1;
        r_cs2   <= w_s2;
        r_err   <= ~w_legal;
      end
    end
  end

  logic                      r_v1, r_v2, r_v3;
  logic                      r_l1, r_l2, r_l3;
  logic [2:0]                r_d1_s1;
  logic [LASTSHIFTWIDTH-1:0] r_d1_s2, r_d2_s2;
  logic                      r_fh;
  logic [1:0]                r_sh0;
  logic [2:0]                r_sh1;
  logic [LASTSHIFTWIDTH-1:0] r_sh2;
  logic                      r_shv, r_shl;

  // Select delay lines: each beat's selects travel with its own valid bit so
  // consecutive commands never mix; a stage holds its select when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      r_l1    <= 1'b0;
      r_l2    <= 1'b0;
      r_l3    <= 1'b0;
      r_d1_s1 <= '0;
      r_d1_s2 <= '0;
      r_d2_s2 <= '0;
      r_fh    <= 1'b0;
      r_sh0   <= '0;
      r_sh1   <= '0;
      r_sh2   <= '0;
      r_shv   <= 1'b0;
      r_shl   <= 1'b0;
    end else begin
      r_v1 <= r_issue;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      r_l1 <= r_issue & (r_cnt == '0);
      r_l2 <= r_l1;
      r_l3 <= r_l2;
      if (r_issue) begin
        r_fh    <= r_vn;
        r_sh0   <= r_cs0;
        r_d1_s1 <= r_cs1;
        r_d1_s2 <= r_cs2;
      end
      if (r_v1) begin
        r_sh1   <= r_d1_s1;
        r_d2_s2 <= r_d1_s2;
      end
      if (r_v2) r_sh2 <= r_d2_s2;
      r_shv <= r_v3;
      r_shl <= r_v3 & r_l3;
    end
  end

  assign o_issue      = r_issue;
  assign o_dist_err   = r_err;
  assign o_first_half = r_fh;
  assign o_shift0     = r_sh0;
  assign o_shift1     = r_sh1;
  assign o_shift2     = r_sh2;
  assign o_sh_valid   = r_shv;
  assign o_sh_last    = r_shl;
endmodule

// File: tb/tb_ldpc_shuffle_ctrl.sv
// Randomized scoreboard bench for ldpc_shuffle_ctrl (FOLDFACTOR 4).
module tb_ldpc_shuffle_ctrl;
  localparam int NUM = 90;
  localparam int L   = 7;
  localparam int LSW = 3;
  localparam int CW  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ldpc_shuffle_ctrl_if #(.LOG2INSTANCES(L), .CNTWIDTH(CW)) rif ();

  logic           o_issue, o_first_half, o_sh_valid, o_sh_last, o_dist_err;
  logic [1:0]     o_shift0;
  logic [2:0]     o_shift1;
  logic [LSW-1:0] o_shift2;

  ldpc_shuffle_ctrl #(.FOLDFACTOR(4), .LASTSHIFTWIDTH(LSW), .CNTWIDTH(CW)) dut (
    .clk(clk), .rst(rst), .req_if(rif),
    .o_issue(o_issue), .o_first_half(o_first_half), .o_shift0(o_shift0),
    .o_shift1(o_shift1), .o_shift2(o_shift2), .o_sh_valid(o_sh_valid),
    .o_sh_last(o_sh_last), .o_dist_err(o_dist_err)
  );

  typedef struct packed {
    logic       first;
    logic       err;
    logic       vn;
    logic [1:0] s0;
    logic [2:0] s1;
    logic [2:0] s2;
    logic       last;
  } beat_t;

  beat_t sb_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    prev_cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: quarter/eighth/unit split from the rotation distance.
  function automatic void model_push(input int d, input int cnt, input bit vn);
    beat_t e;
    int s0, s1, s2, r;
    s0 = 0; s1 = 0; s2 = 0;
    if (d < NUM) begin
      s0 = d / 23;
      if (s0 > 3) s0 = 3;
      r  = d - s0 * 23;
      s1 = r / 3;
      if (s1 > 7) s1 = 7;
      s2 = r - s1 * 3;
    end
    for (int b = 0; b <= cnt; b++) begin
      e.first = (b == 0);
      e.err   = (d >= NUM);
      e.vn    = vn;
      e.s0    = s0[1:0];
      e.s1    = s1[2:0];
      e.s2    = s2[2:0];
      e.last  = (b == cnt);
      sb_q.push_back(e);
    end
  endfunction

  // Monitor: output history so each beat's selects are checked at their stage time.
  logic           h_issue[0:4];
  logic           h_err[0:4];
  logic           h_fh[0:4];
  logic [1:0]     h_s0[0:4];
  logic [2:0]     h_s1[0:4];
  logic [LSW-1:0] h_s2[0:4];

  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      sb_q.delete();
      for (int i = 0; i < 5; i++) begin
        h_issue[i] = 1'b0; h_err[i] = 1'b0; h_fh[i] = 1'b0;
        h_s0[i] = '0; h_s1[i] = '0; h_s2[i] = '0;
      end
    end else begin
      for (int i = 4; i > 0; i--) begin
        h_issue[i] = h_issue[i-1]; h_err[i] = h_err[i-1]; h_fh[i] = h_fh[i-1];
        h_s0[i] = h_s0[i-1]; h_s1[i] = h_s1[i-1]; h_s2[i] = h_s2[i-1];
      end
      h_issue[0] = o_issue; h_err[0] = o_dist_err; h_fh[0] = o_first_half;
      h_s0[0] = o_shift0; h_s1[0] = o_shift1; h_s2[0] = o_shift2;
      if (o_sh_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_sh_valid", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("beat", {20'd0, h_issue[4], h_err[4], h_fh[3], h_s0[3], h_s1[2], h_s2[1], o_sh_last},
                {20'd0, 1'b1, e.first & e.err, e.vn, e.s0, e.s1, e.s2, e.last});
        end
      end
    end
  end

  // Issue one command after gap idle cycles; also checks accept latency.
  task automatic send(input int d, input int cnt, input bit vn, input int gap);
    int waits, exp_waits;
    if (gap > 0) begin
      rif.req_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    rif.req_valid = 1'b1;
    rif.req_dist  = L'(d);
    rif.req_cnt   = CW'(cnt);
    rif.req_vn    = vn;
    exp_waits = (prev_cnt > gap) ? prev_cnt - gap : 0;
    waits = 0;
    @(negedge clk);
    while (!rif.req_ready && waits < 40) begin
      waits++;
      @(negedge clk);
    end
    check("accept_wait", waits, exp_waits);
    if (!rif.req_ready) begin
      rif.req_valid = 1'b0;
      return;
    end
    model_push(d, cnt, vn);
    @(posedge clk);
    #1;
    prev_cnt = cnt;
  endtask

  initial begin
    rst = 1'b1;
    rif.req_valid = 1'b0;
    rif.req_dist  = '0;
    rif.req_cnt   = '0;
    rif.req_vn    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {22'd0, rif.req_ready, o_issue, o_first_half, o_shift0, o_shift1,
                            o_shift2, o_sh_valid, o_sh_last, o_dist_err}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    prev_cnt = 0;

    send(0, 0, 1'b1, 0);
    send(89, 0, 1'b1, 3);
    send(22, 1, 1'b0, 2);
    send(23, 0, 1'b1, 2);
    send(5, 2, 1'b1, 3);
    send(40, 0, 1'b0, 0);
    send(95, 1, 1'b1, 4);
    for (int d = 0; d < NUM; d++) begin
      send(d, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end
    for (int i = 0; i < 60; i++) begin
      send($urandom_range(0, 127), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0);
    end

    // Reset in the middle of a 4-beat command.
    send($urandom_range(0, 89), 3, 1'b1, 20);
    rif.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_rst", {31'd0, rif.req_ready}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      check("no_valid_after_rst", {31'd0, o_sh_valid}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    prev_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      send($urandom_range(0, 127), $urandom_range(0, 5), 1'($urandom_range(0, 1)),
           $urandom_range(0, 1));
    end

    rif.req_valid = 1'b0;
    repeat (25) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
